// File: rtl/sbit_frame_tx_if.sv
// ---------------------------------------------------------------------------
// sbit_frame_tx_if
//
// Purpose: valid/ready input stream carrying one full S-bit frame per
// transfer into sbit_frame_tx.
//
// Signals:
//   sbits_in  [MXSBITS-1:0]  frame to transmit (master -> slave)
//   in_valid                 sbits_in is valid  (master -> slave)
//   in_ready                 slave one-entry buffer is empty (slave -> master)
//
// Modports:
//   master  producer of frames (testbench or upstream logic)
//   slave   sbit_frame_tx
// ---------------------------------------------------------------------------
interface sbit_frame_tx_if #(
    parameter int MXSBITS = 64
);
    logic [MXSBITS-1:0] sbits_in;
    logic               in_valid;
    logic               in_ready;

    modport master (
        output sbits_in,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  sbits_in,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/sbit_frame_tx.sv
// ---------------------------------------------------------------------------
// sbit_frame_tx
//
// Purpose: serialises MXSBITS-bit frames onto MXLINES S-bit lines, WORD_SIZE
// bits per line per frame, one bit per clock, with a start_of_frame marker
// during slot 0. A one-entry buffer decouples the producer from the frame
// cadence; frames sent with no new data are all-zero and counted.
//
// Ports:
//   clock           bit-rate clock, rising edge
//   reset           asynchronous, active-low reset
//   enable          transmit enable (0: lines and marker held low)
//   mask            force all S-bit lines low, marker unaffected
//   prbs_mode       select PRBS-7 test pattern (only with SBIT_TX_PRBS_EN)
//   in_bus          slave side of sbit_frame_tx_if (sbits_in/in_valid/in_ready)
//   sbits_out       registered serial S-bit lines
//   start_of_frame  registered frame marker, high during slot 0
//   underrun_cnt    saturating count of frames sent without new data
//
// Build option:
//   SBIT_TX_PRBS_EN  when defined, adds a PRBS-7 (x^7+x^6+1, seed 7'h7F)
//                    generator selected by prbs_mode; when undefined,
//                    prbs_mode is ignored and no LFSR exists.
// ---------------------------------------------------------------------------
module sbit_frame_tx #(
    parameter int MXSBITS = 64,
    parameter int MXLINES = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               mask,
    input  logic               prbs_mode,
    sbit_frame_tx_if.slave     in_bus,
    output logic [MXLINES-1:0] sbits_out,
    output logic               start_of_frame,
    output logic [15:0]        underrun_cnt
);
    localparam int WORD_SIZE = MXSBITS / MXLINES;

    logic [2:0]         slot_reg;
    logic [2:0]         slot_next;
    logic               boundary;
    logic               transfer;
    logic [MXSBITS-1:0] buf_reg;
    logic [MXSBITS-1:0] buf_next;
    logic               buf_full_reg;
    logic               buf_full_next;
    logic               in_ready_reg;
    logic [15:0]        underrun_cnt_reg;
    logic [15:0]        underrun_cnt_next;
    logic [MXLINES-1:0] lane_bits;
    logic [MXLINES-1:0] line_data;
    logic [MXLINES-1:0] sbits_out_reg;
    logic [MXLINES-1:0] sbits_out_next;
    logic               sof_reg;

    // The edge that ends slot 7 of an enabled frame starts the next frame.
    // With enable low the counter parks at 7, so the first enabled edge is
    // always a boundary.
    assign boundary = enable && (slot_reg == 3'd7);
    assign transfer = in_bus.in_valid && in_ready_reg;

    always_comb begin
        slot_next = 3'd7;
        if (enable) begin
            slot_next = slot_reg + 3'd1;
        end
    end

    // Transfers are only accepted into an empty buffer, so a transfer on a
    // boundary edge cannot collide with the load: the frame takes the (empty)
    // old content and the new word waits for the following frame.
    always_comb begin
        buf_next      = buf_reg;
        buf_full_next = buf_full_reg;
        if (boundary) begin
            buf_full_next = 1'b0;
        end
        if (transfer) begin
            buf_next      = in_bus.sbits_in;
            buf_full_next = 1'b1;
        end
    end

    always_comb begin
        underrun_cnt_next = underrun_cnt_reg;
        if (boundary && !buf_full_reg && (underrun_cnt_reg != 16'hFFFF)) begin
            underrun_cnt_next = underrun_cnt_reg + 16'd1;
        end
    end

    // One shift register per line. Outputs are taken from the next-state
    // value so the registered line carries slot k in the cycle after the
    // edge that moves the counter to k (slot 0 right after the boundary).
    genvar gi;
    generate
        for (gi = 0; gi < MXLINES; gi++) begin : g_lane
            logic [WORD_SIZE-1:0] lane_reg;
            logic [WORD_SIZE-1:0] lane_next;

            always_comb begin
                lane_next = lane_reg;
                if (boundary) begin
                    lane_next = buf_full_reg ? buf_reg[gi*WORD_SIZE +: WORD_SIZE]
                                             : '0;
                end else if (enable) begin
                    lane_next = {1'b0, lane_reg[WORD_SIZE-1:1]};
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    lane_reg <= '0;
                end else begin
                    lane_reg <= lane_next;
                end
            end

            assign lane_bits[gi] = lane_next[0];
        end
    endgenerate

`ifdef SBIT_TX_PRBS_EN
    logic [6:0] lfsr_reg;
    logic       prbs_bit;

    // Fibonacci PRBS-7, taps at bits 7 and 6; the feedback bit is both the
    // transmitted bit and the value shifted in.
    assign prbs_bit = lfsr_reg[6] ^ lfsr_reg[5];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_reg <= 7'h7F;
        end else if (enable) begin
            lfsr_reg <= {lfsr_reg[5:0], prbs_bit};
        end
    end

    assign line_data = prbs_mode ? {MXLINES{prbs_bit}} : lane_bits;
`else
    logic prbs_mode_unused;
    assign prbs_mode_unused = prbs_mode;
    assign line_data        = lane_bits;
`endif

    always_comb begin
        sbits_out_next = '0;
        if (enable && !mask) begin
            sbits_out_next = line_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_reg         <= 3'd7;
            buf_reg          <= '0;
            buf_full_reg     <= 1'b0;
            in_ready_reg     <= 1'b0;
            underrun_cnt_reg <= 16'd0;
            sbits_out_reg    <= '0;
            sof_reg          <= 1'b0;
        end else begin
            slot_reg         <= slot_next;
            buf_reg          <= buf_next;
            buf_full_reg     <= buf_full_next;
            in_ready_reg     <= !buf_full_next;
            underrun_cnt_reg <= underrun_cnt_next;
            sbits_out_reg    <= sbits_out_next;
            sof_reg          <= boundary;
        end
    end

    assign in_bus.in_ready = in_ready_reg;
    assign sbits_out       = sbits_out_reg;
    assign start_of_frame  = sof_reg;
    assign underrun_cnt    = underrun_cnt_reg;

endmodule

// File: tb/tb_sbit_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_sbit_frame_tx
//
// Purpose: self-checking bench for sbit_frame_tx. The stimulus process issues
// directed transfers and pushes the expected frame (tagged with the boundary
// edge at which it must be loaded) into a queue; a monitor process rebuilds
// every transmitted frame from the serial lines, starting at each
// start_of_frame, and compares it and the underrun count against the queue.
// ---------------------------------------------------------------------------
module tb_sbit_frame_tx;
    logic        clock;
    logic        reset;
    logic        enable;
    logic        mask;
    logic        prbs_mode;
    logic [7:0]  sbits_out;
    logic        start_of_frame;
    logic [15:0] underrun_cnt;

    sbit_frame_tx_if #(.MXSBITS(64)) bus ();

    sbit_frame_tx #(
        .MXSBITS(64),
        .MXLINES(8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .mask           (mask),
        .prbs_mode      (prbs_mode),
        .in_bus         (bus),
        .sbits_out      (sbits_out),
        .start_of_frame (start_of_frame),
        .underrun_cnt   (underrun_cnt)
    );

    typedef struct {
        int          bcyc;
        logic [63:0] data;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          b0 = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        mon_on = 1'b0;
    logic [15:0] exp_ur = 16'd0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 20000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Frame whose boundary edge loads a word transferred at edge t: the first
    // boundary strictly after t; pending (-1) while transmission is disabled.
    task automatic send(input logic [63:0] d);
        logic rdy;
        logic done;
        int   bc;
        done = 1'b0;
        bus.sbits_in = d;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            rdy = bus.in_ready;
            tick();
            if (rdy) begin
                done = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            check("send_timeout", 64'(0), 64'(1));
        end else begin
            if (!enable) bc = -1;
            else bc = b0 + 8 * ((cyc - b0) / 8 + 1);
            q.push_back('{bcyc: bc, data: d});
            $display("send %h accepted at edge %0d, frame boundary %0d", d, cyc, bc);
            check("ready_drop", 64'(bus.in_ready), 64'(0));
        end
    endtask

    task automatic set_enable();
        enable = 1'b1;
        b0 = cyc + 1;
        foreach (q[i]) begin
            if (q[i].bcyc < 0) q[i].bcyc = b0;
        end
    endtask

    // Monitor: rebuilds each frame from 8 slots and scores it.
    initial begin : monitor
        int          bc;
        logic [15:0] ur;
        logic        msk;
        logic        aborted;
        logic        extra_sof;
        logic [63:0] got;
        logic [63:0] exp;
        forever begin
            @(negedge clock);
            if (mon_on && start_of_frame) begin
                bc = cyc;
                ur = underrun_cnt;
                msk = mask;
                aborted = 1'b0;
                extra_sof = 1'b0;
                got = '0;
                for (int k = 0; k < 8; k++) begin
                    if (k > 0) begin
                        @(negedge clock);
                        if (!mon_on) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (start_of_frame) extra_sof = 1'b1;
                    end
                    for (int i = 0; i < 8; i++) got[i*8+k] = sbits_out[i];
                end
                if (!aborted) begin
                    check("sof_phase", 64'((bc - b0) % 8), 64'(0));
                    check("sof_slot0_only", 64'(extra_sof), 64'(0));
                    if (q.size() > 0 && q[0].bcyc < bc) begin
                        check("frame_missed", 64'(bc), 64'(q[0].bcyc));
                        void'(q.pop_front());
                    end
                    if (q.size() > 0 && q[0].bcyc == bc) begin
                        exp = q[0].data;
                        void'(q.pop_front());
                    end else begin
                        exp = '0;
                        if (exp_ur != 16'hFFFF) exp_ur = exp_ur + 16'd1;
                    end
                    if (msk) exp = '0;
                    check("frame_data", got, exp);
                    check("underrun", 64'(ur), 64'(exp_ur));
                    $display("frame at edge %0d: data %h underrun %h mask %0d", bc, got, ur, msk);
                end
            end
        end
    end

    initial begin : stimulus
        int b1;
        int b2;
        reset = 1'b0;
        enable = 1'b0;
        mask = 1'b0;
        prbs_mode = 1'b0;
        bus.in_valid = 1'b0;
        bus.sbits_in = '0;

        // Reset state
        repeat (3) tick();
        check("rst_sbits_out", 64'(sbits_out), 64'(0));
        check("rst_sof", 64'(start_of_frame), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_underrun", 64'(underrun_cnt), 64'(0));
        reset = 1'b1;
        tick();
        check("ready_after_reset", 64'(bus.in_ready), 64'(1));

        // Preload one frame while disabled; lines must stay quiet
        send(64'h0123_4567_89AB_CDEF);
        for (int n = 0; n < 20; n++) begin
            tick();
            check("idle_zero", 64'({start_of_frame, sbits_out}), 64'(0));
        end

        // Enable: first edge is a boundary, slot 0 follows immediately
        mon_on = 1'b1;
        set_enable();
        tick();
        check("sof_after_enable", 64'(start_of_frame), 64'(1));
        check("slot0_lines", 64'(sbits_out), 64'(8'hFF));
        tick();
        check("slot1_lines", 64'(sbits_out), 64'(8'h55));
        check("slot1_sof", 64'(start_of_frame), 64'(0));
        wait_until(b0 + 7);
        check("slot7_lines", 64'(sbits_out), 64'(8'h0F));

        // Back-to-back frames; the first lands on a boundary edge
        send(64'h1111_2222_3333_4444);
        send(64'hA5A5_5A5A_F00F_0FF0);
        send(64'hDEAD_BEEF_CAFE_F00D);
        send(64'h8000_0000_0000_0001);

        // Mask one data frame; marker keeps running
        wait_until(b0 + 39);
        mask = 1'b1;
        wait_until(b0 + 47);
        mask = 1'b0;
`ifndef SBIT_TX_PRBS_EN
        prbs_mode = 1'b1;
`endif
        send(64'h7E57_0F0F_3C3C_9669);
        wait_until(b0 + 63);
        enable = 1'b0;
        prbs_mode = 1'b0;

        // Saturation of the underrun counter
        force dut.underrun_cnt_reg = 16'hFFFD;
        tick();
        release dut.underrun_cnt_reg;
        exp_ur = 16'hFFFD;
        check("underrun_preset", 64'(underrun_cnt), 64'(16'hFFFD));
        set_enable();
        b1 = b0;
        wait_until(b1 + 17);
        send(64'hFFFF_FFFF_FFFF_FFFF);
        check("underrun_hold", 64'(underrun_cnt), 64'(16'hFFFF));
        send(64'h0F0F_0F0F_0F0F_0F0F);
        wait_until(b1 + 27);
        check("slot3_ones", 64'(sbits_out), 64'(8'hFF));

        // Asynchronous reset in mid-frame
        mon_on = 1'b0;
        #3;
        reset = 1'b0;
        enable = 1'b0;
        #1;
        check("midrst_sbits_out", 64'(sbits_out), 64'(0));
        check("midrst_sof", 64'(start_of_frame), 64'(0));
        check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
        check("midrst_underrun", 64'(underrun_cnt), 64'(0));
        q.delete();
        exp_ur = 16'd0;
        tick();
        reset = 1'b1;
        tick();
        check("ready_after_midrst", 64'(bus.in_ready), 64'(1));
        mon_on = 1'b1;
        set_enable();
        b2 = b0;
        wait_until(b2 + 16);
        mon_on = 1'b0;
        check("queue_drained", 64'(q.size()), 64'(0));
        enable = 1'b0;

`ifdef SBIT_TX_PRBS_EN
        begin
            logic [6:0] m;
            logic       fb;
            reset = 1'b0;
            tick();
            reset = 1'b1;
            tick();
            prbs_mode = 1'b1;
            enable = 1'b1;
            m = 7'h7F;
            for (int n = 0; n < 254; n++) begin
                tick();
                fb = m[6] ^ m[5];
                m = {m[5:0], fb};
                check("prbs_lines", 64'(sbits_out), 64'({8{fb}}));
            end
            enable = 1'b0;
            prbs_mode = 1'b0;
        end
`endif

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sbit_frame_tx.md
SBIT_FRAME_TX -- requirements
Module: sbit_frame_tx

Interface
REQ-001 Parameter MXSBITS, default 64: S-bits per frame.
REQ-002 Parameter MXLINES, default 8: serial S-bit lines; WORD_SIZE = MXSBITS/MXLINES = 8 bits per line per frame.
REQ-003 clock  input  1  bit-rate clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  transmit enable.
REQ-006 mask  input  1  force all S-bit lines to 0; SOF unaffected.
REQ-007 prbs_mode  input  1  select PRBS test pattern (see Configuration).
REQ-008 sbits_in  input  MXSBITS  frame to transmit.
REQ-009 in_valid  input  1  sbits_in valid.
REQ-010 in_ready  output  1  one-entry buffer empty.
REQ-011 sbits_out  output  MXLINES  serial S-bit lines, registered.
REQ-012 start_of_frame  output  1  frame marker, registered.
REQ-013 underrun_cnt  output  16  frames sent without new data.

Function
REQ-014 A 3-bit slot counter advances 0..7 and wraps when enable=1; when enable=0 it holds at 7.
REQ-015 A frame boundary is the clock edge where the counter is 7 and enable=1.
REQ-016 At a frame boundary, the shift register loads the buffer when the buffer is full, or all-zero otherwise.
REQ-017 The boundary load empties the buffer.
REQ-018 Slot k of a frame drives sbits_out[i] = frame[i*WORD_SIZE+k] for i = 0..MXLINES-1.
REQ-019 start_of_frame is 1 exactly during slot 0 while enable=1.
REQ-020 A transfer occurs on an edge with in_valid=1 and in_ready=1; it writes sbits_in to the buffer and sets it full.
REQ-021 in_ready is a registered !buf_full.
REQ-022 Simultaneous transfer and boundary: the old buffer content goes to the shift register and the new data stays in the buffer, which remains full.
REQ-023 A transfer while the buffer is empty at a boundary edge is not sent in that frame; it is sent in the next frame.
REQ-024 Latency from a transfer into an empty buffer to its slot-0 output is 1 to 8 cycles after the next boundary edge, with no data loss.
REQ-025 underrun_cnt increments at each boundary with an empty buffer and saturates at 0xFFFF.
REQ-026 enable=0 drives sbits_out=0 and start_of_frame=0; buffer transfers continue.
REQ-027 When enable rises, the next edge is a boundary, so the first slot 0 follows enable by one cycle.
REQ-028 mask=1 zeroes sbits_out in the same registered stage; it does not alter frame contents or counters.

Reset
REQ-029 Asserting reset clears immediately: counter=7, shift register=0, buffer empty, sbits_out=0, start_of_frame=0, in_ready=0, underrun_cnt=0, LFSR=7'h7F.
REQ-030 in_ready rises on the first clock edge after reset deasserts.
REQ-031 Reset during a frame aborts it; the buffer content is lost.

Configuration
REQ-032 Macro SBIT_TX_PRBS_EN defined: while prbs_mode=1, every line carries the same PRBS-7 bit (x^7+x^6+1, seed 7'h7F), with the LFSR advancing once per enabled cycle.
REQ-033 With SBIT_TX_PRBS_EN and prbs_mode=1, start_of_frame, the handshake and underrun counting behave unchanged, and buffer data is consumed but not sent.
REQ-034 Macro SBIT_TX_PRBS_EN undefined: prbs_mode is ignored, and no LFSR is synthesized.

Verification
REQ-035 Reset release, enable=1, one transfer of 64'h0123_4567_89AB_CDEF -> at slot k after the next boundary, sbits_out = byte-lane bit k (line 0 slot 0 = 1); start_of_frame high for slot 0 only.
REQ-036 Back-to-back transfers held by in_valid -> in_ready low while the buffer is full; 4 frames sent in order; underrun_cnt unchanged.
REQ-037 Transfer landing on the boundary edge with an empty buffer -> that frame is all zero, underrun_cnt +1, and the data appears in the following frame.
REQ-038 enable low for 20 cycles, then high -> outputs zero while low; start_of_frame asserted one cycle after enable rises; mask=1 zeroes data while start_of_frame keeps toggling.
REQ-039 No data for 70000 frames -> underrun_cnt = 0xFFFF, holds; reset asserted mid-frame -> all outputs 0 immediately.
REQ-040 With SBIT_TX_PRBS_EN and prbs_mode=1 -> all lines match the PRBS-7 reference from seed 7'h7F, with period 127; without the macro, the output equals the normal frame data.
